// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, and the ALU/mux select encodings driven into the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11
`ifdef CTRL_JUMP_EN
    ,S_JUMP    = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM (Moore, plus mem_ready terms in FETCH/MEM_WR); CTRL_JUMP_EN adds j.
// Latency: R/addi/sw 4, lw 5, beq/j 3 cycles, +1 per mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR.
// Backpressure: stalls on mem_ready; after WAIT_LIMIT waiting cycles pulses mem_error and restarts.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int FN_W       = 6,
  parameter int WAIT_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] func,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            instr_done,
  output logic            illegal,
  output logic            mem_error,
  output logic [3:0]      state_o
);

  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             waiting, timeout, funct_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign state_o = state;

  always_comb begin
    funct_ok = (func == FN_W'(FN_ADD)) || (func == FN_W'(FN_SUB)) ||
               (func == FN_W'(FN_AND)) || (func == FN_W'(FN_OR))  ||
               (func == FN_W'(FN_SLT));
    waiting  = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;
    // Fires on the WAIT_LIMIT-th stalled cycle itself; mem_ready in that cycle wins.
    timeout  = (WAIT_LIMIT != 0) && waiting && (wait_cnt == CNT_LAST);
  end

  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    mem_error     = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) begin
          mem_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if ((opcode == OP_W'(OP_R)) && funct_ok)                     state_nxt = S_EXEC_R;
        else if ((opcode == OP_W'(OP_LW)) || (opcode == OP_W'(OP_SW))) state_nxt = S_MEM_ADDR;
        else if (opcode == OP_W'(OP_BEQ))                            state_nxt = S_BRANCH;
        else if (opcode == OP_W'(OP_ADDI))                           state_nxt = S_EXEC_I;
`ifdef CTRL_JUMP_EN
        else if (opcode == OP_W'(OP_J))                              state_nxt = S_JUMP;
`endif
        else begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_nxt = S_MEM_WB;
        else if (timeout) begin
          mem_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        // The store strobe is withheld on the aborting cycle so memory sees no write.
        mem_write  = !timeout;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) begin
          mem_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_nxt = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_nxt = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_nxt     = S_FETCH;
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    wait_cnt_nxt = (state_nxt != state) ? '0 : (waiting ? wait_cnt + 1'b1 : wait_cnt);
  end

endmodule
